// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM state codes, parity codes and limits for the UART RX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int MIN_DATA_W = 5;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module : uart_rx_sync
// Brief  : Multi-flop synchroniser for the RX pin with a tick-qualified fall strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_rx_async,
    output logic o_rx_sync,
    output logic o_rx_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '1;
            r_prev  <= 1'b1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_rx_async};
            if (i_tick) begin
                r_prev <= r_chain[SYNC_STAGES-1];
            end
        end
    end

    // A fall needs a high sample on the previous tick, so a line held low never re-triggers.
    assign o_rx_sync = r_chain[SYNC_STAGES-1];
    assign o_rx_fall = i_tick & r_prev & ~r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module : uart_rx_os
// Brief  : Oversampling UART receiver, runtime data/parity/stop configuration.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int MAX_DATA_W  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_u_clk,
    input  logic                  i_u_rst,
    input  logic                  i_baud_tick,
    input  logic                  i_uart_rx,
    input  logic [3:0]            i_data_bit,
    input  logic [1:0]            i_stop_bit,
    input  logic [1:0]            i_check_bit,
    output logic [MAX_DATA_W-1:0] o_uart_rx_data,
    output logic                  o_uart_rx_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_busy
);

    localparam int              TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   c_MID   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   c_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]      c_MAX_W = 4'(MAX_DATA_W);
    localparam logic [3:0]      c_MIN_W = 4'(MIN_DATA_W);

    logic                  w_rx;
    logic                  w_rx_fall;
    logic [3:0]            w_n_bits;
    logic [1:0]            w_check;
    logic                  w_two_stop;
    logic                  w_ferr_next;
    logic [MAX_DATA_W-1:0] w_aligned;

    logic [2:0]            r_state;
    logic [TW-1:0]         r_tick_cnt;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            r_n_bits;
    logic [1:0]            r_check;
    logic                  r_two_stop;
    logic [MAX_DATA_W-1:0] r_shift;
    logic                  r_par;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_any_one;

    logic [MAX_DATA_W-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr_out;
    logic                  r_ferr_out;
    logic                  r_brk_out;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (i_u_clk),
        .rst        (i_u_rst),
        .i_tick     (i_baud_tick),
        .i_rx_async (i_uart_rx),
        .o_rx_sync  (w_rx),
        .o_rx_fall  (w_rx_fall)
    );

    // Illegal configurations are clamped to the nearest legal value when latched.
    always_comb begin
        w_n_bits = i_data_bit;
        if (i_data_bit < c_MIN_W) begin
            w_n_bits = c_MIN_W;
        end else if (i_data_bit > c_MAX_W) begin
            w_n_bits = c_MAX_W;
        end
        w_check = (i_check_bit == 2'd3) ? PAR_NONE : i_check_bit;
    end

    assign w_two_stop  = (i_stop_bit >= 2'd2);
    assign w_ferr_next = r_ferr | ~w_rx;
    assign w_aligned   = r_shift >> (c_MAX_W - r_n_bits);

    always_ff @(posedge i_u_clk) begin
        if (i_u_rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_n_bits   <= c_MAX_W;
            r_check    <= PAR_NONE;
            r_two_stop <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_any_one  <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_brk_out  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_baud_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_rx_fall) begin
                            r_n_bits   <= w_n_bits;
                            r_check    <= w_check;
                            r_two_stop <= w_two_stop;
                            r_tick_cnt <= '0;
                            r_state    <= START;
                        end
                    end
                    START: begin
                        if (r_tick_cnt == c_MID) begin
                            if (w_rx) begin
                                r_state <= IDLE;
                            end else begin
                                r_tick_cnt <= '0;
                                r_bit_cnt  <= '0;
                                r_shift    <= '0;
                                r_par      <= 1'b0;
                                r_perr     <= 1'b0;
                                r_ferr     <= 1'b0;
                                r_any_one  <= 1'b0;
                                r_state    <= DATA;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (r_tick_cnt == c_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_rx, r_shift[MAX_DATA_W-1:1]};
                            r_par      <= r_par ^ w_rx;
                            r_any_one  <= r_any_one | w_rx;
                            if (r_bit_cnt == r_n_bits - 4'd1) begin
                                r_bit_cnt <= '0;
                                r_state   <= (r_check != PAR_NONE) ? PARITY : STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (r_tick_cnt == c_LAST) begin
                            r_tick_cnt <= '0;
                            r_perr     <= (r_check == PAR_ODD) ? ~(r_par ^ w_rx) : (r_par ^ w_rx);
                            r_any_one  <= r_any_one | w_rx;
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                    STOP: begin
                        if (r_tick_cnt == c_LAST) begin
                            r_tick_cnt <= '0;
                            // Completing at the last stop mid leaves half a bit to catch a back-to-back start.
                            if (r_bit_cnt == {3'b000, r_two_stop}) begin
                                r_data     <= w_aligned;
                                r_perr_out <= r_perr;
                                r_ferr_out <= w_ferr_next;
                                r_brk_out  <= w_ferr_next & ~r_any_one;
                                r_valid    <= 1'b1;
                                r_state    <= IDLE;
                            end else begin
                                r_ferr    <= w_ferr_next;
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_uart_rx_data  = r_data;
    assign o_uart_rx_valid = r_valid;
    assign o_parity_err    = r_perr_out;
    assign o_frame_err     = r_ferr_out;
    assign o_break         = r_brk_out;
    assign o_busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module : tb_uart_rx_os
// Brief  : Directed self-checking bench for uart_rx_os with a frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] data_bit = 4'd8;
    logic [1:0] stop_bit = 2'd1;
    logic [1:0] check_bit = 2'd0;

    wire [7:0] rx_data;
    wire       rx_valid;
    wire       perr;
    wire       ferr;
    wire       brk;
    wire       busy;

    int div = 1;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       b;
    } rec_t;

    rec_t exp_q[$];

    uart_rx_os #(
        .OVERSAMPLE  (16),
        .MAX_DATA_W  (8),
        .SYNC_STAGES (2)
    ) dut (
        .i_u_clk         (clk),
        .i_u_rst         (rst),
        .i_baud_tick     (baud_tick),
        .i_uart_rx       (rx),
        .i_data_bit      (data_bit),
        .i_stop_bit      (stop_bit),
        .i_check_bit     (check_bit),
        .o_uart_rx_data  (rx_data),
        .o_uart_rx_valid (rx_valid),
        .o_parity_err    (perr),
        .o_frame_err     (ferr),
        .o_break         (brk),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c = c + 1;
            if (c >= div) c = 0;
            baud_tick = (c == 0);
        end
    end

    // Correct parity bit for the first n bits of d under mode (1 odd, 2 even).
    function automatic logic par_bit(input logic [7:0] d, input int n, input int mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < n; i++) x = x ^ d[i];
        return (mode == 1) ? ~x : x;
    endfunction

    // What one received frame must report, from the bits put on the wire.
    function automatic rec_t model(input logic [7:0] d, input int n, input int pmode,
                                   input int pbit, input logic stop_lvl);
        rec_t r;
        logic [7:0] mask;
        logic p;
        mask = 8'((1 << n) - 1);
        p = (pmode != 0) ? pbit[0] : 1'b0;
        r.d = d & mask;
        r.p = (pmode != 0) && (p != par_bit(d, n, pmode));
        r.f = (stop_lvl == 1'b0);
        r.b = r.f && (r.d == 8'h00) && (p == 1'b0);
        return r;
    endfunction

    initial begin
        rec_t a;
        rec_t e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                a = {rx_data, perr, ferr, brk};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got data=%h p=%b f=%b b=%b want no valid",
                             a.d, a.p, a.f, a.b);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL frame got data=%h p=%b f=%b b=%b want data=%h p=%b f=%b b=%b",
                                 a.d, a.p, a.f, a.b, e.d, e.p, e.f, e.b);
                    end
                end
            end
        end
    end

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic check_rec(input string name, input rec_t got, input rec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (16 * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input int pmode, input int pbit,
                              input int nstop, input logic stop_lvl, input int gap);
        int p;
        p = (pbit < 0) ? int'(par_bit(d, n, pmode)) : pbit;
        exp_q.push_back(model(d, n, pmode, p, stop_lvl));
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (pmode != 0) drive_bit(p[0]);
        for (int i = 0; i < nstop; i++) drive_bit(stop_lvl);
        for (int i = 0; i < gap; i++) drive_bit(1'b1);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_valid pending=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_cfg(input logic [3:0] n, input logic [1:0] s, input logic [1:0] c);
        data_bit  = n;
        stop_bit  = s;
        check_bit = c;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_data got=%h want=00", rx_data);
        end
        check1("rst_valid", rx_valid, 1'b0);
        check1("rst_perr", perr, 1'b0);
        check1("rst_ferr", ferr, 1'b0);
        check1("rst_break", brk, 1'b0);
        check1("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Hand-computed values that pin the model.
        check1("pin_par_35_even", par_bit(8'h35, 7, 2), 1'b0);
        check1("pin_par_1f_odd", par_bit(8'h1F, 5, 1), 1'b0);
        check_rec("pin_model_a5", model(8'hA5, 8, 0, 0, 1'b1), {8'hA5, 3'b000});
        check_rec("pin_model_35_bad", model(8'h35, 7, 2, 1, 1'b1), {8'h35, 3'b100});
        check_rec("pin_model_break", model(8'h00, 8, 0, 0, 1'b0), {8'h00, 3'b011});

        // 8N1 0xA5
        set_cfg(4'd8, 2'd1, 2'd0);
        send_frame(8'hA5, 8, 0, -1, 1, 1'b1, 2);
        wait_drain("8n1_a5");
        check1("busy_after_a5", busy, 1'b0);

        // 7E2 0x35, good then bad parity
        set_cfg(4'd7, 2'd2, 2'd2);
        send_frame(8'h35, 7, 2, 0, 2, 1'b1, 2);
        send_frame(8'h35, 7, 2, 1, 2, 1'b1, 2);
        wait_drain("7e2_35");

        // 5O1 0x1F with low stop bit
        set_cfg(4'd5, 2'd1, 2'd1);
        send_frame(8'h1F, 5, 1, -1, 1, 1'b0, 2);
        wait_drain("5o1_1f_ferr");

        // Short low glitch
        set_cfg(4'd8, 2'd1, 2'd0);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        check1("glitch_busy_high", busy, 1'b1);
        repeat (20) @(negedge clk);
        check1("glitch_busy_low", busy, 1'b0);

        // Break: three frame times low, then a normal frame
        exp_q.push_back({8'h00, 3'b011});
        rx = 1'b0;
        repeat (3 * 10 * 16) @(negedge clk);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h3C, 8, 0, -1, 1, 1'b1, 2);
        wait_drain("break_then_3c");

        // Reset mid-DATA aborts the frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check1("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        send_frame(8'h81, 8, 0, -1, 1, 1'b1, 2);
        wait_drain("after_rst_81");

        // Parity mode changed mid-frame is ignored
        set_cfg(4'd8, 2'd1, 2'd0);
        fork
            send_frame(8'h6B, 8, 0, -1, 1, 1'b1, 2);
            begin
                repeat (16 * 3) @(negedge clk);
                check_bit = 2'd1;
            end
        join
        check_bit = 2'd0;
        wait_drain("cfg_change_6b");

        // Out-of-range configuration is clamped
        set_cfg(4'd15, 2'd0, 2'd3);
        send_frame(8'h5A, 8, 0, -1, 1, 1'b1, 2);
        wait_drain("clamp_hi_5a");
        set_cfg(4'd2, 2'd3, 2'd0);
        send_frame(8'h0A, 5, 0, -1, 2, 1'b1, 2);
        wait_drain("clamp_lo_0a");

        // Back-to-back frames with a tick every 4th cycle
        set_cfg(4'd8, 2'd1, 2'd0);
        div = 4;
        repeat (16) @(negedge clk);
        send_frame(8'h00, 8, 0, -1, 1, 1'b1, 0);
        send_frame(8'hFF, 8, 0, -1, 1, 1'b1, 2);
        wait_drain("b2b_00_ff");
        div = 1;
        repeat (20) @(negedge clk);
        check1("busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
